// File: rtl/seq_det_param.sv
// Runtime-programmable serial bit-pattern detector (framing / sync-word finder).
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_valid, in  qualified serial input; the first bit received is the pattern MSB
//   cfg_we        loads cfg_pat / cfg_len / cfg_ovl and clears the bit history
//   cfg_pat       pattern; cfg_pat[cfg_len-1] is expected first, cfg_pat[0] last
//   cfg_len       pattern length, legal range 1..PAT_W
//   cfg_ovl       1 = overlapping detection, 0 = non-overlapping
//   cnt_clr       clears the match counter (a same-cycle match still counts)
//   out           combinational match, high while the final pattern bit is presented
//   out_q         out delayed by one cycle
//   match_cnt     saturating match counter
//   cnt_sat       high while match_cnt is all ones
//   cfg_err       configured length is illegal; the detector is disabled
module seq_det_param #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             cnt_clr,
  output logic             out,
  output logic             out_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             cfg_err
);

  localparam int unsigned     LEN_W1   = LEN_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [PAT_W-2:0] hist_q;
  logic [LEN_W-1:0] fill_q;

  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] len_mask;
  logic             pat_hit;
  logic             fill_ok;

  // Match logic: compare the newest len bits (history plus the live bit) to the pattern.
  always_comb begin
    window   = {hist_q, in};
    len_mask = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
    pat_hit = ((window ^ pat_q) & len_mask) == '0;
    // fill >= len-1, evaluated one bit wider so len=0 cannot underflow
    fill_ok = (LEN_W1'(fill_q) + LEN_W1'(1)) >= LEN_W1'(len_q);
    // A config write takes priority over a coincident input bit
    out     = in_valid & ~cfg_we & ~cfg_err & ~rst & fill_ok & pat_hit;
  end

  assign cnt_sat = &match_cnt;

  // Config, history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b1;
    end else begin
      out_q <= out;

      if (cnt_clr) begin
        match_cnt <= out ? CNT_W'(1) : '0;
      end else if (out && !cnt_sat) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end

      if (cfg_we) begin
        pat_q   <= cfg_pat;
        len_q   <= cfg_len;
        ovl_q   <= cfg_ovl;
        hist_q  <= '0;
        fill_q  <= '0;
        cfg_err <= (cfg_len == '0) || (cfg_len > MAX_LEN);
      end else if (in_valid) begin
        if (out && !ovl_q) begin
          // Non-overlapping: the matching bit is not reused for the next match
          hist_q <= '0;
          fill_q <= '0;
        end else begin
          hist_q <= window[PAT_W-2:0];
          if (fill_q != FILL_MAX) begin
            fill_q <= fill_q + LEN_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_param.sv
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_ovl = 1'b1;
  logic       cnt_clr = 1'b0;

  logic       out, out_q, cnt_sat, cfg_err;
  logic [7:0] match_cnt;
  logic       out2, out_q2, cnt_sat2, cfg_err2;
  logic [1:0] match_cnt2;

  seq_det_param #(.PAT_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .out(out), .out_q(out_q), .match_cnt(match_cnt), .cnt_sat(cnt_sat), .cfg_err(cfg_err)
  );

  seq_det_param #(.PAT_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .out(out2), .out_q(out_q2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2), .cfg_err(cfg_err2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: accepted-bit list since the last clear, plus config and counters
  logic       bits[$];
  logic [7:0] m_pat = '0;
  int         m_len = 0;
  logic       m_ovl = 1'b1;
  logic       m_err = 1'b1;
  int         m_cnt = 0;
  int         m_cnt2 = 0;
  logic       m_outq = 1'b0;

  logic        got;
  logic [14:0] hits;
  logic        stream [15] = '{1,0,1,0,1,0,0,1,0,0,1,0,1,1,0};
  logic        short4 [4]  = '{1,1,0,1};
  int          exp_cnt2 [5] = '{1,2,3,3,3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_out(input logic r, input logic v, input logic b, input logic we);
    int n;
    if (r || !v || we || m_err) return 1'b0;
    n = bits.size();
    if (n < m_len - 1) return 1'b0;
    for (int k = 0; k < m_len - 1; k++) begin
      if (bits[n - (m_len - 1) + k] !== m_pat[m_len - 1 - k]) return 1'b0;
    end
    return b === m_pat[0];
  endfunction

  // One clock cycle: drive, check combinational match, advance model, check registers
  task automatic step(input logic r, input logic v, input logic b, input logic we,
                      input logic clr, output logic o);
    logic e;
    @(negedge clk);
    rst = r; in_valid = v; in = b; cfg_we = we; cnt_clr = clr;
    #1;
    e = model_out(r, v, b, we);
    chk("out", 32'(out), 32'(e));
    chk("out2", 32'(out2), 32'(e));
    o = out;
    @(posedge clk);
    if (r) begin
      bits.delete();
      m_pat = '0; m_len = 0; m_ovl = 1'b1; m_err = 1'b1;
      m_cnt = 0; m_cnt2 = 0; m_outq = 1'b0;
    end else begin
      m_outq = e;
      if (clr) begin
        m_cnt  = e ? 1 : 0;
        m_cnt2 = e ? 1 : 0;
      end else if (e) begin
        m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
      end
      if (we) begin
        m_pat = cfg_pat; m_len = int'(cfg_len); m_ovl = cfg_ovl;
        m_err = (m_len == 0) || (m_len > 8);
        bits.delete();
      end else if (v) begin
        if (e && !m_ovl) bits.delete();
        else begin
          bits.push_back(b);
          if (bits.size() > 8) void'(bits.pop_front());
        end
      end
    end
    #1;
    chk("out_q", 32'(out_q), 32'(m_outq));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
    chk("cnt_sat", 32'(cnt_sat), 32'(m_cnt == 255));
    chk("out_q2", 32'(out_q2), 32'(m_outq));
    chk("match_cnt2", 32'(match_cnt2), 32'(m_cnt2));
    chk("cnt_sat2", 32'(cnt_sat2), 32'(m_cnt2 == 3));
  endtask

  task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic ovl);
    logic o;
    cfg_pat = p; cfg_len = l; cfg_ovl = ovl;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, o);
  endtask

  task automatic run_stream(input logic gapped, output logic [14:0] h);
    logic o;
    h = '0;
    for (int i = 0; i < 15; i++) begin
      if (gapped) begin
        repeat ($urandom_range(1, 3)) begin
          step(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0, o);
          chk("gap_out", 32'(o), 32'(0));
        end
      end
      step(1'b0, 1'b1, stream[i], 1'b0, 1'b0, o);
      h[i] = o;
    end
  endtask

  initial begin
    // Reset held with live input
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'(i), 1'b0, 1'b0, got);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, got);
    chk("rst_cfg_err", 32'(cfg_err), 32'(1));
    chk("rst_cnt", 32'(match_cnt), 32'(0));

    // 10010 overlapping, non-overlapping, gapped
    configure(8'b00010010, 4'd5, 1'b1);
    run_stream(1'b0, hits);
    chk("ovl_hits", 32'(hits), 32'h0900);
    chk("ovl_cnt", 32'(match_cnt), 32'(2));
    configure(8'b00010010, 4'd5, 1'b0);
    run_stream(1'b0, hits);
    chk("novl_hits", 32'(hits), 32'h0100);
    chk("novl_cnt", 32'(match_cnt), 32'(1));
    configure(8'b00010010, 4'd5, 1'b1);
    run_stream(1'b1, hits);
    chk("gap_hits", 32'(hits), 32'h0900);
    chk("gap_cnt", 32'(match_cnt), 32'(2));

    // Illegal lengths disable the detector
    configure(8'hff, 4'd0, 1'b1);
    run_stream(1'b0, hits);
    chk("len0_err", 32'(cfg_err), 32'(1));
    chk("len0_hits", 32'(hits), 32'(0));
    configure(8'hff, 4'd9, 1'b1);
    run_stream(1'b0, hits);
    chk("len9_err", 32'(cfg_err), 32'(1));
    chk("len9_cnt", 32'(match_cnt), 32'(0));

    // Single-bit pattern
    configure(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, short4[i], 1'b0, 1'b0, got);
    chk("len1_cnt", 32'(match_cnt), 32'(3));

    // Config write coincident with a bit that would complete 10010
    configure(8'b00010010, 4'd5, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, got);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, got);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, got);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, got);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, got);
    chk("cfgwe_drop", 32'(got), 32'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, got);
    chk("cfgwe_hist_clr", 32'(got), 32'(0));

    // Narrow counter saturation and clear-with-match
    configure(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, got);
      chk("sat_cnt2", 32'(match_cnt2), 32'(exp_cnt2[i]));
      chk("sat_flag2", 32'(cnt_sat2), 32'(i >= 2));
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, got);
    chk("clr_match_cnt", 32'(match_cnt), 32'(1));
    chk("clr_match_cnt2", 32'(match_cnt2), 32'(1));

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic r, we, clr;
      r   = ($urandom_range(0, 99) < 1);
      we  = ($urandom_range(0, 99) < 3);
      clr = ($urandom_range(0, 99) < 3);
      if (we) begin
        cfg_pat = 8'($urandom);
        cfg_len = ($urandom_range(0, 99) < 85) ? 4'($urandom_range(1, 4))
                                               : 4'($urandom_range(0, 9));
        cfg_ovl = 1'($urandom);
      end
      step(r, ($urandom_range(0, 99) < 80), 1'($urandom), we, clr, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
Parametrised serial bit-pattern detector, the successor to the fixed 10010 Mealy detector. Pattern and length are runtime-programmable up to PAT_W bits. Overlapping or non-overlapping detection is selectable, with a qualified input strobe, a Mealy (same-cycle) and a registered match output, and a saturating match counter. Sits on a serial input stream as a framing/sync-word detector.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width
LEN_W, $clog2(PAT_W+1), width of pat_len (derived; do not override)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  qualifies in; bit consumed on a rising edge when high
in  input  1  serial data bit, first-received bit is MSB of pattern
cfg_we  input  1  load pat/pat_len/overlap into config registers
cfg_pat  input  PAT_W  pattern; cfg_pat[pat_len-1] is the first bit expected, cfg_pat[0] the last
cfg_len  input  LEN_W  pattern length, valid range 1..PAT_W
cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  input  1  clear match counter
out  output  1  Mealy match: combinational, high in the cycle the final pattern bit is presented
out_q  output  1  out registered, one cycle later
match_cnt  output  CNT_W  number of matches, saturating
cnt_sat  output  1  high while match_cnt is all ones
cfg_err  output  1  registered: config length is 0 or > PAT_W (detector disabled)

Behaviour:
- Reset (rst=1 at edge): pat=0, len=0, ovl=1, history=0, fill=0, out_q=0, match_cnt=0, cfg_err=1 (len 0 = disabled). out=0 during reset.
- History: shift register of PAT_W-1 bits plus saturating fill counter (0..PAT_W-1). Both update only on accepted bits (in_valid=1). Each accepted bit shifts into the LSB. fill increments, saturating at PAT_W-1.
- out = in_valid & ~cfg_err & ~rst & (fill >= len-1) & ({history[len-2:0], in} == pat[len-1:0]). For len=1: in == pat[0]. Mask unused high bits by len.
- Overlap mode: history shifts normally on a match.
- Non-overlap mode: on a match, history and fill clear to 0 at that edge (the matching bit is not retained). The next match needs len fresh bits.
- in_valid=0: no shift, out=0, state held.
- cfg_we: registers pat/len/ovl, clears history and fill, and sets cfg_err = (cfg_len==0 || cfg_len>PAT_W). If in_valid is high the same cycle, config wins: the bit is dropped and out is forced 0 that cycle.
- out_q <= out every cycle; 0 after reset.
- match_cnt: +1 on each cycle out=1, holds at 2^CNT_W-1 (no wrap). cnt_sat combinational from match_cnt.
- cnt_clr: clears match_cnt; if out=1 the same cycle, match_cnt becomes 1 (clear then count). Does not touch history.
- Reset mid-stream discards partial history and the counter. cfg must be rewritten after reset.
- No latency beyond the stated: out same cycle, out_q and match_cnt update at the edge consuming the matching bit (visible next cycle).

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in toggling -> out=0, out_q=0, match_cnt=0, cfg_err=1 throughout and after release.
- Overlap 10010 (cfg_pat=8'b00010010, len=5, ovl=1). Stream 1,0,1,0,1,0,0,1,0,0,1,0,1,1,0, one bit per cycle -> out high on bits 9 and 12 only, match_cnt=2, out_q follows one cycle late.
- Same stream with ovl=0 -> out high on bit 9 only (bit 12 suppressed), match_cnt=1.
- Gapped input: same overlap stream with in_valid low for 1-3 random cycles between bits -> identical matches on the same accepted bits, out=0 in all gap cycles.
- Config edges: len=0 and len=9 -> cfg_err=1, no matches. len=1, pat=1, stream 1,1,0,1 -> 3 matches. cfg_we coincident with in_valid -> bit dropped, history cleared.
- Counter: CNT_W=2, len=1 pattern 1 streamed 5 times -> match_cnt 1,2,3,3,3 with cnt_sat=1 from the third match. cnt_clr coincident with a match -> match_cnt=1.
